// File: rtl/rle_pixel_stream.sv
// rle_pixel_stream: captures 18-bit run-length instructions from the flash fetcher into a small
// FIFO and expands them into one RGB222 colour per VGA pixel request.
// Optional build macro PIXEL_DOUBLE_EN: every run step takes two pixel requests, so each run
// covers twice as many pixels. The default build (macro undefined) is one step per request.
module rle_pixel_stream #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] instr,
  input  logic        instr_valid,
  output logic        shift_data,
  input  logic        pixel_req,
  input  logic        frame_start,
  output logic [5:0]  rgb,
  output logic        underrun,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LvlFull  = LW'(FIFO_DEPTH);
  // One slot is kept free for the instruction the fetcher already has in flight.
  localparam logic [LW-1:0] ShiftMax = LW'(FIFO_DEPTH - 2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Capture and FIFO state
  logic          valid_q;
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [17:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;

  // Run register and outputs
  state_e        state_q, state_d;
  logic [5:0]    color_q, color_d;
  logic [11:0]   left_q, left_d;
  logic [5:0]    rgb_q, rgb_d;
  logic          shift_q, shift_d;
  logic          underrun_q, underrun_d;
  logic          overflow_q, overflow_d;
`ifdef PIXEL_DOUBLE_EN
  logic          half_q, half_d;
`endif

  // Combinational helpers
  logic          push_ev;
  logic          push_acc;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [17:0]   head;
  logic          step;
  logic          under_set;
  logic          over_set;

  // Next-state: run expansion, FIFO bookkeeping, flow control and sticky flags.
  always_comb begin
    push_ev    = instr_valid & ~valid_q;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlFull);
    head       = mem_q[rptr_q];

    state_d    = state_q;
    color_d    = color_q;
    left_d     = left_q;
    rgb_d      = '0;
    pop        = 1'b0;
    under_set  = 1'b0;
    step       = 1'b1;
`ifdef PIXEL_DOUBLE_EN
    half_d     = half_q;
`endif

    case (state_q)
      StIdle: begin
        // A request here is served as black; loading a run never serves a pixel itself.
        if (pixel_req) begin
          under_set = 1'b1;
        end
        if (!fifo_empty) begin
          pop     = 1'b1;
          color_d = head[17:12];
          left_d  = head[11:0];
          state_d = StRun;
        end
      end
      StRun: begin
        if (pixel_req) begin
          rgb_d = color_q;
`ifdef PIXEL_DOUBLE_EN
          half_d = ~half_q;
          step   = half_q;
`endif
          if (step) begin
            if (left_q != 12'd0) begin
              left_d = left_q - 12'd1;
            end else if (!fifo_empty) begin
              // Chain straight into the next run so there is no bubble between runs.
              pop     = 1'b1;
              color_d = head[17:12];
              left_d  = head[11:0];
`ifdef PIXEL_DOUBLE_EN
              half_d  = 1'b0;
`endif
            end else begin
              state_d = StIdle;
`ifdef PIXEL_DOUBLE_EN
              half_d  = 1'b0;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef PIXEL_DOUBLE_EN
    if (frame_start) begin
      half_d = 1'b0;
    end
`endif

    // Pop happens first, so a full FIFO still accepts a word when it pops this cycle.
    push_acc = push_ev & (~fifo_full | pop);
    over_set = push_ev & fifo_full & ~pop;

    mem_d = mem_q;
    if (push_acc) begin
      mem_d[wptr_q] = instr;
    end
    wptr_d  = push_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    if (push_acc && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push_acc) begin
      level_d = level_q - LW'(1);
    end

    shift_d = (level_d <= ShiftMax);

    // frame_start clears, but a set event in the same cycle wins.
    underrun_d = (frame_start ? 1'b0 : underrun_q) | under_set;
    overflow_d = (frame_start ? 1'b0 : overflow_q) | over_set;
  end

  // Control state, run register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      color_q    <= '0;
      left_q     <= '0;
      rgb_q      <= '0;
      shift_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PIXEL_DOUBLE_EN
      half_q     <= 1'b0;
`endif
    end else begin
      valid_q    <= instr_valid;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      color_q    <= color_d;
      left_q     <= left_d;
      rgb_q      <= rgb_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
`ifdef PIXEL_DOUBLE_EN
      half_q     <= half_d;
`endif
    end
  end

  // FIFO storage; contents are only meaningful below the level count, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rgb        = rgb_q;
  assign shift_data = shift_q;
  assign underrun   = underrun_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rle_pixel_stream.sv
// Self-checking bench for rle_pixel_stream: directed scenarios plus randomized traffic, all
// compared against a queue-and-pixel-count model of the instruction stream.
module tb_rle_pixel_stream;

  localparam int DEPTH = 4;
`ifdef PIXEL_DOUBLE_EN
  localparam int MULT = 2;
`else
  localparam int MULT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] instr;
  logic        instr_valid;
  logic        shift_data;
  logic        pixel_req;
  logic        frame_start;
  logic [5:0]  rgb;
  logic        underrun;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rle_pixel_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .shift_data  (shift_data),
    .pixel_req   (pixel_req),
    .frame_start (frame_start),
    .rgb         (rgb),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  // Reference model: pending instructions in a queue, current run as a remaining pixel count.
  logic [17:0] mq[$];
  bit          m_active;
  int          m_left;
  logic [5:0]  m_color;
  logic [5:0]  m_rgb;
  bit          m_under;
  bit          m_over;
  bit          m_shift;
  bit          m_prev;

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_left   = 0;
    m_color  = '0;
    m_rgb    = '0;
    m_under  = 0;
    m_over   = 0;
    m_shift  = 0;
    m_prev   = 0;
  endtask

  task automatic model_load();
    logic [17:0] w;
    w        = mq.pop_front();
    m_color  = w[17:12];
    m_left   = (int'(w[11:0]) + 1) * MULT;
    m_active = 1;
  endtask

  task automatic model_step();
    bit push_ev;
    bit under_set;
    bit over_set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    push_ev   = instr_valid && !m_prev;
    m_prev    = instr_valid;
    under_set = 0;
    over_set  = 0;
    m_rgb     = '0;
    if (!m_active) begin
      if (pixel_req) under_set = 1;
      if (mq.size() > 0) model_load();
    end else if (pixel_req) begin
      m_rgb  = m_color;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (mq.size() > 0) model_load();
        else m_active = 0;
      end
    end
    if (push_ev) begin
      if (mq.size() < DEPTH) mq.push_back(instr);
      else over_set = 1;
    end
`ifdef PIXEL_DOUBLE_EN
    // Frame start realigns to the first pixel of a pair.
    if (frame_start && m_active && (m_left % 2 == 1)) m_left = m_left + 1;
`endif
    m_under = (frame_start ? 1'b0 : m_under) | under_set;
    m_over  = (frame_start ? 1'b0 : m_over) | over_set;
    m_shift = (mq.size() <= DEPTH - 2);
  endtask

  task automatic cycle(input bit v, input logic [17:0] w, input bit pr, input bit fs);
    instr_valid = v;
    instr       = w;
    pixel_req   = pr;
    frame_start = fs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL reset_rgb: got %h expected 00", rgb); end
    total++; if (shift_data !== 1'b0) begin bad++; $display("FAIL reset_shift: got %b expected 0", shift_data); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    cycle(0, '0, 0, 0);
    total++; if (shift_data !== 1'b1) begin bad++; $display("FAIL reset_shift_after: got %b expected 1", shift_data); end
  endtask

  task automatic test_single_run();
    do_reset();
    cycle(1, 18'h3F002, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== m_rgb) begin bad++; $display("FAIL single_rgb_model[%0d]: got %h expected %h", i, rgb, m_rgb); end
      total++; if (underrun !== m_under) begin bad++; $display("FAIL single_underrun_model[%0d]: got %b expected %b", i, underrun, m_under); end
`ifndef PIXEL_DOUBLE_EN
      total++; if (rgb !== ((i < 3) ? 6'h3F : 6'h00)) begin bad++; $display("FAIL single_rgb[%0d]: got %h expected %h", i, rgb, (i < 3) ? 6'h3F : 6'h00); end
      total++; if (underrun !== (i >= 3)) begin bad++; $display("FAIL single_underrun[%0d]: got %b expected %b", i, underrun, i >= 3); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [4];
    exp_seq = '{6'h30, 6'h0C, 6'h0C, 6'h00};
    do_reset();
    cycle(1, 18'h30000, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(1, 18'h0C001, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== m_rgb) begin bad++; $display("FAIL b2b_rgb_model[%0d]: got %h expected %h", i, rgb, m_rgb); end
`ifndef PIXEL_DOUBLE_EN
      total++; if (rgb !== exp_seq[i]) begin bad++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", i, rgb, exp_seq[i]); end
`endif
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    // Push 1 is taken straight into the run register, so six pushes are needed to overflow.
    for (int k = 1; k <= 6; k++) begin
      cycle(1, {6'(k), 12'd0}, 0, 0);
      total++; if (shift_data !== m_shift) begin bad++; $display("FAIL fill_shift_model[%0d]: got %b expected %b", k, shift_data, m_shift); end
      total++; if (shift_data !== (k <= 3)) begin bad++; $display("FAIL fill_shift[%0d]: got %b expected %b", k, shift_data, k <= 3); end
      total++; if (overflow !== (k == 6)) begin bad++; $display("FAIL fill_overflow[%0d]: got %b expected %b", k, overflow, k == 6); end
      cycle(0, '0, 0, 0);
    end
    for (int j = 0; j < 6; j++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== m_rgb) begin bad++; $display("FAIL drain_rgb_model[%0d]: got %h expected %h", j, rgb, m_rgb); end
`ifndef PIXEL_DOUBLE_EN
      total++; if (rgb !== ((j < 5) ? 6'(j + 1) : 6'h00)) begin bad++; $display("FAIL drain_rgb[%0d]: got %h expected %h", j, rgb, (j < 5) ? 6'(j + 1) : 6'h00); end
`endif
    end
  endtask

  task automatic test_valid_hold();
    do_reset();
    cycle(1, {6'h15, 12'd1}, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 18'($urandom), 0, 0);
    cycle(0, '0, 0, 0);
    total++; if (shift_data !== 1'b1) begin bad++; $display("FAIL hold_shift: got %b expected 1", shift_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL hold_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== m_rgb) begin bad++; $display("FAIL hold_rgb_model[%0d]: got %h expected %h", i, rgb, m_rgb); end
`ifndef PIXEL_DOUBLE_EN
      total++; if (rgb !== ((i < 2) ? 6'h15 : 6'h00)) begin bad++; $display("FAIL hold_rgb[%0d]: got %h expected %h", i, rgb, (i < 2) ? 6'h15 : 6'h00); end
`endif
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    cycle(0, '0, 1, 1);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL fs_set_wins: got %b expected 1", underrun); end
    cycle(0, '0, 0, 1);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL fs_clear: got %b expected 0", underrun); end
    total++; if (underrun !== m_under) begin bad++; $display("FAIL fs_model: got %b expected %b", underrun, m_under); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cycle(1, {6'h2A, 12'd50}, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    total++; if (rgb !== 6'h2A) begin bad++; $display("FAIL midrun_rgb: got %h expected 2a", rgb); end
    rst_n = 1'b0;
    cycle(0, '0, 1, 0);
    rst_n = 1'b1;
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL midrun_reset_rgb: got %h expected 00", rgb); end
    total++; if (shift_data !== 1'b0) begin bad++; $display("FAIL midrun_reset_shift: got %b expected 0", shift_data); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== 6'h00) begin bad++; $display("FAIL midrun_after_rgb[%0d]: got %h expected 00", i, rgb); end
      total++; if (underrun !== 1'b1) begin bad++; $display("FAIL midrun_after_underrun[%0d]: got %b expected 1", i, underrun); end
    end
  endtask

`ifdef PIXEL_DOUBLE_EN
  task automatic test_double();
    do_reset();
    cycle(1, 18'h3F001, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 1, 0);
      total++; if (rgb !== ((i < 4) ? 6'h3F : 6'h00)) begin bad++; $display("FAIL double_rgb[%0d]: got %h expected %h", i, rgb, (i < 4) ? 6'h3F : 6'h00); end
      total++; if (underrun !== (i >= 4)) begin bad++; $display("FAIL double_underrun[%0d]: got %b expected %b", i, underrun, i >= 4); end
    end
  endtask
`endif

  task automatic test_random();
    bit          v;
    logic [17:0] w;
    logic [11:0] run;
    do_reset();
    v = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) v = ~v;
      run = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 40)) : 12'($urandom_range(0, 3));
      w   = {6'($urandom), run};
      cycle(v, w, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      total++; if (rgb !== m_rgb) begin bad++; $display("FAIL rand_rgb[%0d]: got %h expected %h", c, rgb, m_rgb); end
      total++; if (shift_data !== m_shift) begin bad++; $display("FAIL rand_shift[%0d]: got %b expected %b", c, shift_data, m_shift); end
      total++; if (underrun !== m_under) begin bad++; $display("FAIL rand_underrun[%0d]: got %b expected %b", c, underrun, m_under); end
      total++; if (overflow !== m_over) begin bad++; $display("FAIL rand_overflow[%0d]: got %b expected %b", c, overflow, m_over); end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    pixel_req   = 1'b0;
    frame_start = 1'b0;
    model_reset();
    test_reset();
    test_single_run();
    test_back_to_back();
    test_fill_overflow();
    test_valid_hold();
    test_frame_start();
    test_reset_mid_run();
`ifdef PIXEL_DOUBLE_EN
    test_double();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
